// File: rtl/led_pattern_checker_pkg.sv
// Shared LED-word constants, FSM encoding and the rotate helper.
// No timing of its own; used by the checker and the rotation matcher.
package led_pattern_checker_pkg;

    localparam int LED_W      = 12;
    localparam int LED_PHASES = 12;
    localparam logic [LED_W-1:0] DEF_BASE_SEQ = 12'b000011101101;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // The top half of the doubled word shifted left by k is the word rotated left by k.
    function automatic logic [LED_W-1:0] rotl(input logic [LED_W-1:0] w, input logic [3:0] k);
        logic [2*LED_W-1:0] d;
        d = {w, w} << k;
        return d[2*LED_W-1:LED_W];
    endfunction

endpackage

// File: rtl/led_pattern_checker_if.sv
// LED word stream in, lock/phase/error status out.
// Latency and backpressure are defined by the checker; step qualifies leds.
interface led_pattern_checker_if;
    import led_pattern_checker_pkg::*;

    logic [LED_W-1:0] leds;
    logic             step;
    logic             locked;
    logic [3:0]       phase;
    logic             err_pulse;
    logic [7:0]       err_cnt;
    logic [7:0]       wraps;

    modport master (
        output leds, step,
        input  locked, phase, err_pulse, err_cnt, wraps
    );

    modport slave (
        input  leds, step,
        output locked, phase, err_pulse, err_cnt, wraps
    );
endinterface

// File: rtl/led_rot_match.sv
// Finds which rotation of base equals word (lowest index wins).
// Latency 0 (combinational); no backpressure.
module led_rot_match
    import led_pattern_checker_pkg::*;
(
    input  logic [LED_W-1:0] word,
    input  logic [LED_W-1:0] base,
    output logic             hit,
    output logic [3:0]       idx
);

    always_comb begin
        hit = 1'b0;
        idx = 4'd0;
        for (int k = LED_PHASES - 1; k >= 0; k--) begin
            if (word == rotl(base, 4'(k))) begin
                hit = 1'b1;
                idx = 4'(k);
            end
        end
    end

endmodule

// File: rtl/led_pattern_checker.sv
// Locks onto a rotating LED pattern, tracks phase, counts errors and wraps.
// Latency 1 clk from a step word to outputs; no backpressure, step=0 freezes all state.
module led_pattern_checker
    import led_pattern_checker_pkg::*;
#(
    parameter logic [LED_W-1:0] BASE_SEQ    = DEF_BASE_SEQ,
    parameter int               LOCK_THRESH = 2,
    parameter int               LOSS_THRESH = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    led_pattern_checker_if.slave   chk
);

    logic [1:0] rst_sync;
    logic       run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rst_sync <= 2'b00;
        else        rst_sync <= {rst_sync[0], 1'b1};
    end
    assign run = rst_sync[1];

    logic       any_hit;
    logic [3:0] any_idx;

    led_rot_match u_match (
        .word (chk.leds),
        .base (BASE_SEQ),
        .hit  (any_hit),
        .idx  (any_idx)
    );

    state_t     state;
    logic [2:0] good_cnt;
    logic [2:0] miss_cnt;
    logic [3:0] phase_r;
    logic       locked_r;
    logic       err_pulse_r;
    logic [7:0] err_cnt_r;
    logic [7:0] wraps_r;

    logic [3:0] phase_nxt;
    logic       exp_hit;
    logic       good_done;
    logic       miss_done;

    assign phase_nxt = (phase_r == 4'(LED_PHASES - 1)) ? 4'd0 : phase_r + 4'd1;
    assign exp_hit   = (chk.leds == rotl(BASE_SEQ, phase_nxt));
    assign good_done = (int'(good_cnt) + 1 >= LOCK_THRESH);
    assign miss_done = (int'(miss_cnt) + 1 >= LOSS_THRESH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_SEARCH;
            good_cnt    <= 3'd0;
            miss_cnt    <= 3'd0;
            phase_r     <= 4'd0;
            locked_r    <= 1'b0;
            err_pulse_r <= 1'b0;
            err_cnt_r   <= 8'd0;
            wraps_r     <= 8'd0;
        end else begin
            err_pulse_r <= 1'b0;
            if (run && chk.step) begin
                unique case (state)
                    ST_SEARCH: begin
                        if (any_hit) begin
                            phase_r  <= any_idx;
                            good_cnt <= 3'd1;
                            if (LOCK_THRESH <= 1) begin
                                state    <= ST_LOCKED;
                                locked_r <= 1'b1;
                                miss_cnt <= 3'd0;
                            end else begin
                                state <= ST_VERIFY;
                            end
                        end
                    end
                    ST_VERIFY: begin
                        if (exp_hit) begin
                            phase_r  <= phase_nxt;
                            good_cnt <= good_cnt + 3'd1;
                            if (good_done) begin
                                state    <= ST_LOCKED;
                                locked_r <= 1'b1;
                                miss_cnt <= 3'd0;
                            end
                        end else if (any_hit) begin
                            phase_r  <= any_idx;
                            good_cnt <= 3'd1;
                        end else begin
                            state    <= ST_SEARCH;
                            good_cnt <= 3'd0;
                        end
                    end
                    ST_LOCKED: begin
                        // Phase advances on every word so a glitch does not misalign tracking.
                        phase_r <= phase_nxt;
                        if (exp_hit) begin
                            miss_cnt <= 3'd0;
                            if (phase_nxt == 4'd0) wraps_r <= wraps_r + 8'd1;
                        end else begin
                            err_pulse_r <= 1'b1;
                            if (err_cnt_r != 8'hFF) err_cnt_r <= err_cnt_r + 8'd1;
                            if (miss_done) begin
                                state    <= ST_SEARCH;
                                locked_r <= 1'b0;
                                miss_cnt <= 3'd0;
                                good_cnt <= 3'd0;
                            end else begin
                                miss_cnt <= miss_cnt + 3'd1;
                            end
                        end
                    end
                    default: state <= ST_SEARCH;
                endcase
            end
        end
    end

    assign chk.locked    = locked_r;
    assign chk.phase     = phase_r;
    assign chk.err_pulse = err_pulse_r;
    assign chk.err_cnt   = err_cnt_r;
    assign chk.wraps     = wraps_r;

endmodule

// File: tb/tb_led_pattern_checker.sv
// Directed + randomized bench for led_pattern_checker against a rule-level reference model.
module tb_led_pattern_checker;

    logic clk;
    logic rst_n;

    led_pattern_checker_if ifc ();

    led_pattern_checker dut (
        .clk   (clk),
        .rst_n (rst_n),
        .chk   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [11:0] BASE = 12'b000011101101;
    localparam int LOCK_T = 2;
    localparam int LOSS_T = 3;

    int vectors;
    int miscompares;
    int gen_idx;

    // Reference model state: 0 searching, 1 verifying, 2 locked.
    int m_mode, m_phase, m_good, m_miss, m_err, m_wraps;
    bit m_pulse, m_locked;

    function automatic logic [11:0] rot(input int k);
        logic [11:0] r;
        r = BASE;
        for (int i = 0; i < k; i++) r = {r[10:0], r[11]};
        return r;
    endfunction

    function automatic int match_of(input logic [11:0] w);
        for (int k = 0; k < 12; k++) if (rot(k) == w) return k;
        return -1;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_phase = 0; m_good = 0; m_miss = 0;
        m_err = 0; m_wraps = 0; m_pulse = 0; m_locked = 0;
    endtask

    task automatic model_step(input bit stp, input logic [11:0] w);
        int j, nk;
        m_pulse = 0;
        if (!stp) return;
        j  = match_of(w);
        nk = (m_phase + 1) % 12;
        if (m_mode == 0) begin
            if (j >= 0) begin
                m_phase = j; m_good = 1;
                if (LOCK_T == 1) begin m_mode = 2; m_locked = 1; m_miss = 0; end
                else m_mode = 1;
            end
        end else if (m_mode == 1) begin
            if (j == nk) begin
                m_phase = nk; m_good++;
                if (m_good >= LOCK_T) begin m_mode = 2; m_locked = 1; m_miss = 0; end
            end else if (j >= 0) begin
                m_phase = j; m_good = 1;
            end else begin
                m_mode = 0; m_good = 0;
            end
        end else begin
            if (j == nk) begin
                m_miss = 0;
                if (nk == 0) m_wraps = (m_wraps + 1) % 256;
            end else begin
                m_pulse = 1;
                if (m_err < 255) m_err++;
                m_miss++;
                if (m_miss >= LOSS_T) begin
                    m_mode = 0; m_locked = 0; m_miss = 0; m_good = 0;
                end
            end
            m_phase = nk;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        vectors++;
        chk("locked",    32'(ifc.locked),    32'(m_locked));
        chk("phase",     32'(ifc.phase),     32'(m_phase));
        chk("err_pulse", 32'(ifc.err_pulse), 32'(m_pulse));
        chk("err_cnt",   32'(ifc.err_cnt),   32'(m_err));
        chk("wraps",     32'(ifc.wraps),     32'(m_wraps));
    endtask

    // Drive one cycle, update model at the edge, sample 1 time unit later.
    task automatic apply(input bit stp, input logic [11:0] w);
        ifc.step = stp;
        ifc.leds = w;
        @(posedge clk);
        model_step(stp, w);
        #1;
        check_all();
    endtask

    task automatic good_word();
        apply(1'b1, rot(gen_idx));
        gen_idx = (gen_idx + 1) % 12;
    endtask

    task automatic bad_word(input logic [11:0] w);
        apply(1'b1, w);
        gen_idx = (gen_idx + 1) % 12;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        ifc.step = 1'b0;
        ifc.leds = 12'h000;
        model_reset();
        #1;
        check_all();
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_all();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) apply(1'b0, 12'($urandom));
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        gen_idx = 0;
        rst_n = 1'b1;
        ifc.step = 1'b0;
        ifc.leds = 12'h000;
        #2;

        // Reset state.
        do_reset();

        // Clean stream from phase 0: lock after second word, 10 wraps in 120 more.
        good_word();
        chk("locked_after_1", 32'(ifc.locked), 32'd0);
        good_word();
        chk("locked_after_2", 32'(ifc.locked), 32'd1);
        for (int i = 0; i < 120; i++) good_word();
        chk("wraps_120", 32'(ifc.wraps), 32'd10);
        chk("err_clean", 32'(ifc.err_cnt), 32'd0);

        // Single glitch keeps lock and alignment.
        bad_word(12'hFFF);
        chk("glitch_pulse", 32'(ifc.err_pulse), 32'd1);
        chk("glitch_locked", 32'(ifc.locked), 32'd1);
        good_word();
        chk("glitch_pulse_clear", 32'(ifc.err_pulse), 32'd0);
        for (int i = 0; i < 4; i++) good_word();

        // Loss after three zero words, then resync in two.
        for (int i = 0; i < 3; i++) bad_word(12'h000);
        chk("loss_locked", 32'(ifc.locked), 32'd0);
        chk("loss_err", 32'(ifc.err_cnt), 32'd4);
        good_word();
        good_word();
        chk("resync", 32'(ifc.locked), 32'd1);

        // Bring err_cnt to 5, then reset asynchronously mid-lock.
        bad_word(12'hFFF);
        good_word();
        chk("err_five", 32'(ifc.err_cnt), 32'd5);
        do_reset();

        // step gating with toggling leds after a mid-stream lock.
        apply(1'b1, 12'b011101101000);
        chk("mid_phase3", 32'(ifc.phase), 32'd3);
        apply(1'b1, 12'b111011010000);
        chk("mid_locked", 32'(ifc.locked), 32'd1);
        chk("mid_phase4", 32'(ifc.phase), 32'd4);
        gen_idx = 5;
        for (int i = 0; i < 5; i++) apply(1'b0, 12'($urandom));

        // Randomized mix of correct, corrupted and random words with random step.
        for (int i = 0; i < 400; i++) begin
            int r;
            bit s;
            r = $urandom_range(0, 9);
            s = ($urandom_range(0, 7) != 0);
            if (!s)          apply(1'b0, 12'($urandom));
            else if (r < 6)  good_word();
            else if (r == 6) bad_word(12'hFFF);
            else if (r == 7) bad_word(12'($urandom));
            else if (r == 8) bad_word(rot($urandom_range(0, 11)));
            else begin
                gen_idx = $urandom_range(0, 11);
                good_word();
            end
        end

        // Saturation: repeated lock then three bad words until err_cnt hits 255.
        for (int n = 0; n < 200 && m_err < 255; n++) begin
            good_word();
            good_word();
            for (int i = 0; i < 3; i++) bad_word(12'h000);
        end
        good_word();
        good_word();
        bad_word(12'h000);
        chk("err_saturated", 32'(ifc.err_cnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
